// File: rtl/cmd_word_decoder_pkg.sv
// Shared command layout, opcodes and decoder state for the command path.
// Optional feature macro: CMD_DEC_LEN_CHECK_EN (exact per-opcode length check).
package cmd_word_decoder_pkg;

   localparam int unsigned cmd_buf_width_gp = 32;

   typedef enum logic [7:0] {
      CMD_FETCH     = 8'hF0,
      CMD_DISP      = 8'hF1,
      CMD_TILE      = 8'hF2,
      CMD_WAIT_DISP = 8'hF3,
      CMD_WAIT_TILE = 8'hF4
   } cmd_op_s;

   typedef struct packed {
      logic [7:0] rsvd;
      logic [7:0] len;
      logic [7:0] id;
      logic [7:0] op;
   } cmd_header_s;

   localparam logic [7:0] cmd_fetch_len_gp     = 8'd12;
   localparam logic [7:0] cmd_disp_len_gp      = 8'd12;
   localparam logic [7:0] cmd_tile_len_gp      = 8'd12;
   localparam logic [7:0] cmd_wait_disp_len_gp = 8'd4;
   localparam logic [7:0] cmd_wait_tile_len_gp = 8'd4;

   typedef enum logic [1:0] {
      S_HDR,
      S_PAY,
      S_EMIT,
      S_DRAIN
   } cmd_dec_state_e;

   function automatic logic [6:0] cmd_len_words(input logic [7:0] len);
      logic [8:0] sum;
      sum = {1'b0, len} + 9'd3;
      return sum[8:2];
   endfunction

endpackage

// File: rtl/cmd_len_lookup.sv
// Pure opcode decode: reports whether an opcode is known and its
// required payload size in bytes.
module cmd_len_lookup
   import cmd_word_decoder_pkg::*;
(
   input  logic [7:0] op_i,
   output logic       known_o,
   output logic [7:0] len_o
);

   always_comb begin
      known_o = 1'b1;
      len_o   = '0;
      unique case (op_i)
         CMD_FETCH:     len_o = cmd_fetch_len_gp;
         CMD_DISP:      len_o = cmd_disp_len_gp;
         CMD_TILE:      len_o = cmd_tile_len_gp;
         CMD_WAIT_DISP: len_o = cmd_wait_disp_len_gp;
         CMD_WAIT_TILE: len_o = cmd_wait_tile_len_gp;
         default:       known_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cmd_word_decoder.sv
// Assembles header + payload words into decoded commands; drains rejects.
// Optional feature macro: CMD_DEC_LEN_CHECK_EN.
module cmd_word_decoder
   import cmd_word_decoder_pkg::*;
#(
   parameter int MAX_PAYLOAD_WORDS = 3,
   parameter int ERR_CNT_WIDTH     = 8
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_word_valid,
   output logic                        o_word_ready,
   input  logic [cmd_buf_width_gp-1:0] i_word,
   output logic                        o_cmd_valid,
   input  logic                        i_cmd_ready,
   output logic [7:0]                  o_cmd_op,
   output logic [7:0]                  o_cmd_id,
   output logic [MAX_PAYLOAD_WORDS*32-1:0] o_cmd_payload,
   input  logic                        i_err_clr,
   output logic                        o_err_unknown_op,
   output logic                        o_err_len,
   output logic [ERR_CNT_WIDTH-1:0]    o_err_cnt
);

   localparam int PW = MAX_PAYLOAD_WORDS * 32;

   cmd_dec_state_e           state_q, state_d;
   logic [7:0]               op_q, op_d, id_q, id_d;
   logic [PW-1:0]            pay_q, pay_d;
   logic [6:0]               cnt_q, cnt_d, nw_q, nw_d;
   logic                     unk_q, unk_d, len_q, len_d;
   logic [ERR_CNT_WIDTH-1:0] ecnt_q, ecnt_d;

   cmd_header_s hdr;
   logic [6:0]  hdr_nw;
   logic        known;
   logic [7:0]  exp_len;
   logic        word_acc, hdr_acc, last_word;
   logic        bad_op, bad_len, reject;
   logic        unused_bits;

   assign hdr    = cmd_header_s'(i_word);
   assign hdr_nw = cmd_len_words(hdr.len);

   cmd_len_lookup u_len_lookup (
      .op_i    (hdr.op),
      .known_o (known),
      .len_o   (exp_len)
   );

   assign word_acc  = i_word_valid && o_word_ready;
   assign hdr_acc   = word_acc && (state_q == S_HDR);
   assign last_word = (cnt_q == nw_q - 7'd1);
   assign bad_op    = !known;

`ifdef CMD_DEC_LEN_CHECK_EN
   assign bad_len = (int'(hdr_nw) > MAX_PAYLOAD_WORDS)
                 || (known && (hdr.len != exp_len));
   assign unused_bits = ^hdr.rsvd;
`else
   assign bad_len = int'(hdr_nw) > MAX_PAYLOAD_WORDS;
   assign unused_bits = ^{hdr.rsvd, exp_len};
`endif

   assign reject = hdr_acc && (bad_op || bad_len);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= S_HDR;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HDR: if (hdr_acc) begin
            if (reject) state_d = (hdr_nw == 7'd0) ? S_HDR  : S_DRAIN;
            else        state_d = (hdr_nw == 7'd0) ? S_EMIT : S_PAY;
         end
         S_PAY:   if (word_acc && last_word) state_d = S_EMIT;
         S_EMIT:  if (i_cmd_ready)           state_d = S_HDR;
         S_DRAIN: if (word_acc && last_word) state_d = S_HDR;
         default: state_d = S_HDR;
      endcase
   end

   always_comb begin
      o_cmd_valid  = (state_q == S_EMIT);
      o_word_ready = (state_q != S_EMIT);
   end

   // Drained words only advance the counter; payload stays cleared.
   always_comb begin
      op_d  = op_q;
      id_d  = id_q;
      pay_d = pay_q;
      cnt_d = cnt_q;
      nw_d  = nw_q;
      if (hdr_acc) begin
         op_d  = hdr.op;
         id_d  = hdr.id;
         pay_d = '0;
         cnt_d = '0;
         nw_d  = hdr_nw;
      end else if (word_acc) begin
         cnt_d = cnt_q + 7'd1;
         if (state_q == S_PAY) begin
            for (int k = 0; k < MAX_PAYLOAD_WORDS; k++) begin
               if (cnt_q == 7'(k)) pay_d[k*32 +: 32] = i_word;
            end
         end
      end
   end

   always_comb begin
      unk_d  = i_err_clr ? 1'b0 : unk_q;
      len_d  = i_err_clr ? 1'b0 : len_q;
      ecnt_d = i_err_clr ? '0 : ecnt_q;
      if (reject) begin
         if (bad_op)  unk_d = 1'b1;
         if (bad_len) len_d = 1'b1;
         if (ecnt_d != '1) ecnt_d = ecnt_d + ERR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         op_q   <= '0;
         id_q   <= '0;
         pay_q  <= '0;
         cnt_q  <= '0;
         nw_q   <= '0;
         unk_q  <= 1'b0;
         len_q  <= 1'b0;
         ecnt_q <= '0;
      end else begin
         op_q   <= op_d;
         id_q   <= id_d;
         pay_q  <= pay_d;
         cnt_q  <= cnt_d;
         nw_q   <= nw_d;
         unk_q  <= unk_d;
         len_q  <= len_d;
         ecnt_q <= ecnt_d;
      end
   end

   assign o_cmd_op         = op_q;
   assign o_cmd_id         = id_q;
   assign o_cmd_payload    = pay_q;
   assign o_err_unknown_op = unk_q;
   assign o_err_len        = len_q;
   assign o_err_cnt        = ecnt_q;

endmodule

// File: tb/tb_cmd_word_decoder.sv
// Directed, table-driven bench for cmd_word_decoder.
// Expectations follow CMD_DEC_LEN_CHECK_EN when it is defined.
module tb_cmd_word_decoder;

   localparam int MPW = 3;
   localparam int PW  = MPW * 32;
`ifdef CMD_DEC_LEN_CHECK_EN
   localparam bit LC = 1'b1;
`else
   localparam bit LC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          word_valid = 1'b0;
   logic [31:0]   word = '0;
   logic          cmd_ready = 1'b0;
   logic          err_clr = 1'b0;
   logic          word_ready, cmd_valid, err_unk, err_len;
   logic [7:0]    cmd_op, cmd_id, err_cnt;
   logic [PW-1:0] cmd_payload;

   cmd_word_decoder #(.MAX_PAYLOAD_WORDS(MPW), .ERR_CNT_WIDTH(8)) dut (
      .i_clk            (clk),
      .i_reset_n        (rst_n),
      .i_word_valid     (word_valid),
      .o_word_ready     (word_ready),
      .i_word           (word),
      .o_cmd_valid      (cmd_valid),
      .i_cmd_ready      (cmd_ready),
      .o_cmd_op         (cmd_op),
      .o_cmd_id         (cmd_id),
      .o_cmd_payload    (cmd_payload),
      .i_err_clr        (err_clr),
      .o_err_unknown_op (err_unk),
      .o_err_len        (err_len),
      .o_err_cnt        (err_cnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Called at #1 after an edge; returns at #1 after the accepting edge.
   task automatic send_word(input logic [31:0] w);
      int n;
      n = 0;
      word_valid = 1'b1;
      word = w;
      while (!word_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("send_timeout", 1'b1, 1'b0);
      @(posedge clk); #1;
      word_valid = 1'b0;
   endtask

   typedef struct packed {
      logic [31:0]      hdr;
      logic [3:0][31:0] w;
      logic [2:0]       nw;
      logic             ok;
      logic             unk;
      logic [95:0]      pay;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] h,
                               input logic [31:0] w0, w1, w2, w3,
                               input int nw, input bit ok, input bit unk,
                               input logic [95:0] pay);
      vec_t r;
      r.hdr = h;
      r.w   = {w3, w2, w1, w0};
      r.nw  = 3'(nw);
      r.ok  = ok;
      r.unk = unk;
      r.pay = pay;
      return r;
   endfunction

   vec_t vt[10];
   int   exp_cnt;
   bit   exp_unk, exp_lenf;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = mk(32'h000C05F0, 32'h2000_0000, 32'h40, 32'h1, 0, 3, 1, 0,
                 {32'h1, 32'h40, 32'h2000_0000});
      vt[1] = mk(32'h000409F4, 32'h7, 0, 0, 0, 1, 1, 0, {64'h0, 32'h7});
      vt[2] = mk(32'h000801AA, 32'h1111, 32'h2222, 0, 0, 2, 0, 1, '0);
      vt[3] = mk(32'h000C06F0, 32'hA, 32'hB, 32'hC, 0, 3, 1, 0,
                 {32'hC, 32'hB, 32'hA});
      vt[4] = mk(32'h000803F2, 32'h11, 32'h22, 0, 0, 2, !LC, 0,
                 {32'h0, 32'h22, 32'h11});
      vt[5] = mk(32'h000007F1, 0, 0, 0, 0, 0, !LC, 0, '0);
      vt[6] = mk(32'h001008F3, 32'h1, 32'h2, 32'h3, 32'h4, 4, 0, 0, '0);
      vt[7] = mk(32'h00040AF3, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, 0,
                 {64'h0, 32'hDEAD_BEEF});
      vt[8] = mk(32'hFF0C0BF0, 32'h5, 32'h6, 32'h7, 0, 3, 1, 0,
                 {32'h7, 32'h6, 32'h5});
      vt[9] = mk(32'h00050CF4, 32'h1, 32'h2, 0, 0, 2, !LC, 0,
                 {32'h0, 32'h2, 32'h1});

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", cmd_valid, 1'b0);
      chk("rst_ready", word_ready, 1'b1);
      chk("rst_op", cmd_op, 8'h0);
      chk("rst_id", cmd_id, 8'h0);
      chk("rst_payload", cmd_payload, 96'h0);
      chk("rst_flags", {err_unk, err_len}, 2'b00);
      chk("rst_cnt", err_cnt, 8'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      exp_cnt  = 0;
      exp_unk  = 1'b0;
      exp_lenf = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send_word(vt[i].hdr);
         if (!vt[i].ok) begin
            exp_cnt++;
            if (vt[i].unk) exp_unk = 1'b1;
            else           exp_lenf = 1'b1;
            chk($sformatf("v%0d_unk", i), err_unk, exp_unk);
            chk($sformatf("v%0d_lenflag", i), err_len, exp_lenf);
            chk($sformatf("v%0d_errcnt", i), err_cnt, 8'(exp_cnt));
         end
         for (int k = 0; k < int'(vt[i].nw); k++) begin
            chk($sformatf("v%0d_w%0d_novalid", i, k), cmd_valid, 1'b0);
            send_word(vt[i].w[k]);
         end
         chk($sformatf("v%0d_valid", i), cmd_valid, vt[i].ok);
         if (vt[i].ok) begin
            chk($sformatf("v%0d_op", i), cmd_op, vt[i].hdr[7:0]);
            chk($sformatf("v%0d_id", i), cmd_id, vt[i].hdr[15:8]);
            chk($sformatf("v%0d_payload", i), cmd_payload, vt[i].pay);
            chk($sformatf("v%0d_busy", i), word_ready, 1'b0);
            cmd_ready = 1'b1;
            @(posedge clk); #1;
            cmd_ready = 1'b0;
            chk($sformatf("v%0d_consumed", i), cmd_valid, 1'b0);
         end
         chk($sformatf("v%0d_ready", i), word_ready, 1'b1);
      end
      chk("tbl_errcnt", err_cnt, 8'(exp_cnt));

      // backpressure with the next header already waiting
      send_word(32'h000C07F0);
      send_word(32'h100);
      send_word(32'h200);
      send_word(32'h300);
      word_valid = 1'b1;
      word = 32'h000421F4;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_valid", c), cmd_valid, 1'b1);
         chk($sformatf("bp%0d_ready", c), word_ready, 1'b0);
         chk($sformatf("bp%0d_opid", c), {cmd_op, cmd_id}, 16'hF007);
         chk($sformatf("bp%0d_payload", c), cmd_payload,
             {32'h300, 32'h200, 32'h100});
         @(posedge clk); #1;
      end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      chk("bp_release_valid", cmd_valid, 1'b0);
      chk("bp_release_ready", word_ready, 1'b1);
      @(posedge clk); #1;
      word_valid = 1'b0;
      send_word(32'h55);
      chk("bp_next_valid", cmd_valid, 1'b1);
      chk("bp_next_opid", {cmd_op, cmd_id}, 16'hF421);
      chk("bp_next_payload", cmd_payload, {64'h0, 32'h55});
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;

      // reset in the middle of a command
      send_word(32'h000C30F0);
      send_word(32'h99);
      rst_n = 1'b0;
      #3;
      chk("mid_rst_valid", cmd_valid, 1'b0);
      chk("mid_rst_ready", word_ready, 1'b1);
      chk("mid_rst_opid", {cmd_op, cmd_id}, 16'h0);
      chk("mid_rst_payload", cmd_payload, 96'h0);
      chk("mid_rst_err", {err_unk, err_len, err_cnt}, 10'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_word(32'h000431F3);
      send_word(32'h77);
      chk("post_rst_valid", cmd_valid, 1'b1);
      chk("post_rst_opid", {cmd_op, cmd_id}, 16'hF331);
      chk("post_rst_payload", cmd_payload, {64'h0, 32'h77});
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;

      // 260 zero-length unknown commands, one per cycle
      word_valid = 1'b1;
      word = 32'h0000_00AA;
      repeat (260) @(posedge clk);
      #1;
      word_valid = 1'b0;
      chk("sat_cnt", err_cnt, 8'd255);
      chk("sat_unk", err_unk, 1'b1);
      chk("sat_ready", word_ready, 1'b1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("clr_cnt", err_cnt, 8'd0);
      chk("clr_flags", {err_unk, err_len}, 2'b00);

      // clear and rejection in the same cycle
      word_valid = 1'b1;
      word = 32'h0000_00AA;
      err_clr = 1'b1;
      @(posedge clk); #1;
      word_valid = 1'b0;
      err_clr = 1'b0;
      chk("clr_rej_cnt", err_cnt, 8'd1);
      chk("clr_rej_unk", err_unk, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cmd_word_decoder.md
# cmd_word_decoder

Parametrised command word decoder between the host command FIFO and the master controller dispatch logic. Consumes the 32-bit command word stream and assembles each command from its header plus payload words. Emits one decoded command per handshake and rejects malformed commands by draining their payload. Unlike the fixed command-layout definitions it builds on, it supports configurable payload depth, per-opcode length checking, and error accounting.

## Interface
- `MAX_PAYLOAD_WORDS`, default 3: payload capacity in 32-bit words. Must be ≥ 1.
- `ERR_CNT_WIDTH`, default 8: width of the saturating error counter.
- `i_clk` in 1: clock.
- `i_reset_n` in 1: reset. Asynchronous, active-low.
- `i_word_valid` in 1: input command word valid.
- `o_word_ready` out 1: decoder accepts the word.
- `i_word` in 32: command word (`cmd_buf_width_gp`).
- `o_cmd_valid` out 1: decoded command valid.
- `i_cmd_ready` in 1: consumer accepts the command.
- `o_cmd_op` out 8: opcode (`cmd_op_s`).
- `o_cmd_id` out 8: command id.
- `o_cmd_payload` out `MAX_PAYLOAD_WORDS*32`: payload; Word1 sits at [31:0].
- `i_err_clr` in 1: clears the sticky error flags and the counter.
- `o_err_unknown_op` out 1: sticky flag, unknown opcode seen.
- `o_err_len` out 1: sticky flag, length violation seen.
- `o_err_cnt` out `ERR_CNT_WIDTH`: count of rejected commands, saturating.

## Operation
- Header word fields:
  - [7:0] op
  - [15:8] id
  - [23:16] len, payload length in bytes
  - [31:24] reserved, ignored
- Payload word count is `nw = ceil(len/4)`.
- FSM has four states: `S_HDR`, `S_PAY`, `S_EMIT`, `S_DRAIN`.
- `S_HDR`, on header accept:
  - Latch op and id; clear the payload register; set the word counter to 0.
  - Goto `S_DRAIN` if the command is rejected (see rejection rules below).
  - Otherwise goto `S_EMIT` if `nw == 0`, else `S_PAY`.
- `S_PAY`: each accepted word k (0-based) is written to `payload[32k+:32]`. After word `nw-1`, goto `S_EMIT`.
- `S_EMIT`: `o_cmd_valid` = 1. Goto `S_HDR` on `i_cmd_ready`.
- `S_DRAIN`: accept and discard `nw` words, then goto `S_HDR`. If `nw == 0`, return to `S_HDR` directly from the header cycle.
- A command is rejected when either:
  - op is not one of F0–F4, which sets `o_err_unknown_op`; or
  - `nw > MAX_PAYLOAD_WORDS`, or the length check fails (see Configuration), which sets `o_err_len`.
- Every rejection increments `o_err_cnt`, which saturates at all-ones.
- `o_word_ready` = (state != `S_EMIT`).
- Payload bits beyond `nw` words read as 0.
- `o_cmd_op`, `o_cmd_id` and `o_cmd_payload` stay stable while `o_cmd_valid` && !`i_cmd_ready`.
- Simultaneous `i_err_clr` and a new rejection in the same cycle: the rejection wins. Flags are 1 and the counter is 1.

## Timing
- Reset values:
  - state `S_HDR`
  - `o_cmd_valid` 0
  - `o_word_ready` 1
  - op, id, payload 0
  - flags 0, `o_err_cnt` 0
- Latency: `o_cmd_valid` rises the cycle after the last payload word is accepted, or the cycle after the header when `nw == 0`.
- Throughput: 1 + `nw` + 1 cycles per command when the consumer is always ready.
- Handshakes are AXI-style valid/ready. Valid does not depend on ready. Transfer occurs on valid && ready at the rising edge.
- Error flags update the cycle after the header is accepted.
- Reset mid-command: the partial command is discarded. Stream words that follow are interpreted as headers.

## Configuration
- Macro: `CMD_DEC_LEN_CHECK_EN`.
- Defined: len must equal the exact per-opcode size, else the command is rejected with `o_err_len`. Required sizes in bytes:
  - fetch 12
  - disp 12
  - tile 12
  - wait_disp 4
  - wait_tile 4
- Undefined: any len with `nw ≤ MAX_PAYLOAD_WORDS` is accepted. Short commands are zero-padded.

## Structure
- Shared package holds:
  - the `cmd_op_s` opcodes
  - `cmd_header_s`
  - `cmd_buf_width_gp`
  - the new per-opcode byte-length constants (`cmd_fetch_len_gp` etc.)
  - a new state enum `cmd_dec_state_e`
- Module-local: counters, payload register, error logic.
- Sub-module: `cmd_len_lookup`, a pure function block mapping op to {known, expected_len}. It is reused by the dispatcher.

## Test plan
- Fetch command, no backpressure:
  - Stimulus: header 0x0C05_F0 (len 12, id 5); words 0x2000_0000, 0x0000_0040, 0x1.
  - Response: `o_cmd_valid` 1 cycle after word 3; op F0, id 5, payload {0x1, 0x40, 0x2000_0000}.
- Wait_tile command:
  - Stimulus: header 0x0409_F4 (len 4, id 9); word 0x0000_0007.
  - Response: op F4, payload[31:0] = 7, upper payload bits 0.
- Unknown opcode:
  - Stimulus: header op 0xAA, len 8, followed by 2 words, then a valid fetch command.
  - Response: both payload words are drained; `o_err_unknown_op` = 1; `o_err_cnt` = 1; the fetch command decodes correctly.
- Length check, with the macro defined:
  - Stimulus: tile op F2 with len 8, plus its payload words.
  - Response: `o_err_len` = 1 and no `o_cmd_valid`.
  - Without the macro, the same command is accepted with payload word 3 = 0.
- Backpressure:
  - Stimulus: hold `i_cmd_ready` = 0 for 5 cycles.
  - Response: outputs stable, `o_word_ready` = 0 throughout; on release, the next header is accepted the following cycle.
- Reset and counter saturation:
  - Stimulus: assert `i_reset_n` low after 1 payload word.
  - Response: all outputs return to reset values.
  - Separately: 260 rejected commands leave `o_err_cnt` = 255; `i_err_clr` then clears it to 0.
